// File: rtl/fp_sqrt_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sqrt_scheduler
//  Description : Round-robin front end sharing one pipelined fp_sqrt among
//                NREQ requesters, with in-order tagged results and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_sqrt_scheduler #(
    parameter int NREQ      = 4,
    parameter int SIG_WIDTH = 23,
    parameter int EX_WIDTH  = 8,
    parameter int LAT       = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NREQ-1:0]                         req_valid,
    output logic [NREQ-1:0]                         req_ready,
    input  logic [NREQ*(SIG_WIDTH+EX_WIDTH+1)-1:0]  req_a,
    input  logic [NREQ*3-1:0]                       req_round,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [$clog2(NREQ)-1:0]                 res_id,
    output logic [SIG_WIDTH+EX_WIDTH:0]             res_z,
    output logic [7:0]                              res_status,
    output logic [SIG_WIDTH+EX_WIDTH:0]             sq_a,
    output logic [2:0]                              sq_round,
    output logic                                    sq_enable,
    input  logic [SIG_WIDTH+EX_WIDTH:0]             sq_z,
    input  logic [7:0]                              sq_status,
    input  logic                                    flush_req,
    output logic                                    flush_done,
    output logic [$clog2(LAT+2)-1:0]                inflight
);

    localparam int c_W    = SIG_WIDTH + EX_WIDTH + 1;
    localparam int c_IDW  = $clog2(NREQ);
    localparam int c_INFW = $clog2(LAT + 2);
    localparam logic [c_IDW:0] c_NREQ_X = (c_IDW+1)'(NREQ);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_IDW-1:0]      r_ptr;
    logic [c_IDW-1:0]      w_ptr_nxt;
    logic                  w_can_grant;
    logic                  w_grant_any;
    logic [c_IDW-1:0]      w_grant_idx;
    logic [c_IDW:0]        w_rr_sum;
    logic [c_IDW-1:0]      w_rr_idx;
    logic                  w_tail_v;
    logic [c_IDW-1:0]      w_tail_id;
    logic [c_INFW-1:0]     w_tag_cnt;
    logic [c_INFW-1:0]     w_inflight;
    logic                  r_res_valid;
    logic [c_IDW-1:0]      r_res_id;
    logic [c_W-1:0]        r_res_z;
    logic [7:0]            r_res_status;

    // A full, unconsumed result register stalls the whole datapath.
    assign sq_enable   = ~r_res_valid | res_ready;
    assign w_can_grant = (r_state == c_ST_RUN) & sq_enable;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_rr_sum    = '0;
        w_rr_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_rr_sum = {1'b0, r_ptr} + (c_IDW+1)'(k);
            w_rr_idx = (w_rr_sum >= c_NREQ_X) ? c_IDW'(w_rr_sum - c_NREQ_X)
                                              : c_IDW'(w_rr_sum);
            if (w_can_grant && !w_grant_any && req_valid[w_rr_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_rr_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_grant_idx == c_IDW'(NREQ - 1)) ? '0
                                                         : w_grant_idx + c_IDW'(1);

    always_comb begin
        req_ready = '0;
        sq_a      = '0;
        sq_round  = '0;
        if (w_grant_any) begin
            req_ready[w_grant_idx] = 1'b1;
            sq_a     = req_a[int'(w_grant_idx)*c_W +: c_W];
            sq_round = req_round[int'(w_grant_idx)*3 +: 3];
        end
    end

    // Tag pipeline tracks which requester owns each op inside fp_sqrt.
    generate
        if (LAT > 0) begin : g_tag
            logic [LAT-1:0]   r_tag_v;
            logic [c_IDW-1:0] r_tag_id [LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_tag_v <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        r_tag_id[i] <= '0;
                    end
                end else if (sq_enable) begin
                    r_tag_v[0]  <= w_grant_any;
                    r_tag_id[0] <= w_grant_idx;
                    for (int i = 1; i < LAT; i++) begin
                        r_tag_v[i]  <= r_tag_v[i-1];
                        r_tag_id[i] <= r_tag_id[i-1];
                    end
                end
            end

            always_comb begin
                w_tag_cnt = '0;
                for (int i = 0; i < LAT; i++) begin
                    w_tag_cnt = w_tag_cnt + c_INFW'(r_tag_v[i]);
                end
            end

            assign w_tail_v  = r_tag_v[LAT-1];
            assign w_tail_id = r_tag_id[LAT-1];
        end else begin : g_no_tag
            assign w_tag_cnt = '0;
            assign w_tail_v  = w_grant_any;
            assign w_tail_id = w_grant_idx;
        end
    endgenerate

    assign w_inflight = w_tag_cnt + c_INFW'(r_res_valid);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RUN:   if (flush_req) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_inflight == '0) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_RUN;
            default:    w_state_nxt = c_ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_res_valid  <= 1'b0;
            r_res_id     <= '0;
            r_res_z      <= '0;
            r_res_status <= '0;
        end else begin
            if (w_grant_any) begin
                r_ptr <= w_ptr_nxt;
            end
            if (sq_enable) begin
                r_res_valid  <= w_tail_v;
                r_res_id     <= w_tail_id;
                r_res_z      <= sq_z;
                r_res_status <= sq_status;
            end
        end
    end

    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_z      = r_res_z;
    assign res_status = r_res_status;
    assign flush_done = (r_state == c_ST_DONE);
    assign inflight   = w_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fp_sqrt_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_sqrt_scheduler
//  Description : Self-checking bench for fp_sqrt_scheduler with a stand-in
//                fp_sqrt pipeline and a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_sqrt_scheduler;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int W    = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*3-1:0] req_round;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_id;
    logic [W-1:0]      res_z;
    logic [7:0]        res_status;
    logic [W-1:0]      sq_a;
    logic [2:0]        sq_round;
    logic              sq_enable;
    logic [W-1:0]      sq_z;
    logic [7:0]        sq_status;
    logic              flush_req;
    logic              flush_done;
    logic [1:0]        inflight;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_sqrt_scheduler #(
        .NREQ(NREQ), .SIG_WIDTH(23), .EX_WIDTH(8), .LAT(LAT)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_round(req_round),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_z(res_z), .res_status(res_status),
        .sq_a(sq_a), .sq_round(sq_round), .sq_enable(sq_enable),
        .sq_z(sq_z), .sq_status(sq_status),
        .flush_req(flush_req), .flush_done(flush_done),
        .inflight(inflight)
    );

    // Stand-in fp_sqrt: exact for 4.0, otherwise a distinctive bijection-ish tag.
    function automatic logic [W-1:0] fake_z(input logic [W-1:0] a, input logic [2:0] rnd);
        if (a == 32'h4080_0000) return 32'h4000_0000 ^ {29'b0, rnd};
        return {a[15:0], a[31:16]} ^ 32'h3C00_0000 ^ {29'b0, rnd};
    endfunction

    function automatic logic [7:0] fake_s(input logic [W-1:0] a, input logic [2:0] rnd);
        return {rnd, a[4:0] ^ a[28:24]};
    endfunction

    logic [W+2:0] r_p0 = '0;
    logic [W+2:0] r_p1 = '0;
    always @(posedge clk) begin
        if (sq_enable) begin
            r_p0 <= {sq_round, sq_a};
            r_p1 <= r_p0;
        end
    end
    assign sq_z      = fake_z(r_p1[W-1:0], r_p1[W+2:W]);
    assign sq_status = fake_s(r_p1[W-1:0], r_p1[W+2:W]);

    // Reference model: ordered queue of accepted ops, each with cycles left to appear.
    int           m_ptr = 0;
    int           m_st  = 0;
    int           q_id[$];
    int           q_cnt[$];
    logic [W-1:0] q_z[$];
    logic [7:0]   q_s[$];
    bit           m_out_valid;
    bit           m_en;
    int           m_gnt;

    logic [NREQ-1:0] exp_req_ready;
    logic [W-1:0]    exp_sq_a;
    logic [2:0]      exp_sq_round;
    logic            exp_res_valid;
    logic [1:0]      exp_res_id;
    logic [W-1:0]    exp_z;
    logic [7:0]      exp_s;
    logic [1:0]      exp_inflight;
    logic            exp_flush_done;
    logic            exp_sq_enable;

    task automatic model_eval();
        m_out_valid = (q_cnt.size() > 0) && (q_cnt[0] == 0);
        m_en  = !m_out_valid || res_ready;
        m_gnt = -1;
        if (m_st == 0 && m_en) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_gnt < 0 && req_valid[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
            end
        end
        exp_req_ready = '0;
        exp_sq_a      = '0;
        exp_sq_round  = '0;
        if (m_gnt >= 0) begin
            exp_req_ready[m_gnt] = 1'b1;
            exp_sq_a     = req_a[m_gnt*W +: W];
            exp_sq_round = req_round[m_gnt*3 +: 3];
        end
        exp_sq_enable  = m_en;
        exp_res_valid  = m_out_valid;
        exp_res_id     = m_out_valid ? 2'(q_id[0]) : 2'd0;
        exp_z          = m_out_valid ? q_z[0] : '0;
        exp_s          = m_out_valid ? q_s[0] : '0;
        exp_inflight   = 2'(q_cnt.size());
        exp_flush_done = (m_st == 2);
    endtask

    task automatic model_step();
        if (reset) begin
            m_ptr = 0;
            m_st  = 0;
            q_id.delete(); q_cnt.delete(); q_z.delete(); q_s.delete();
        end else begin
            case (m_st)
                0:       if (flush_req) m_st = 1;
                1:       if (q_cnt.size() == 0) m_st = 2;
                default: m_st = 0;
            endcase
            if (m_en) begin
                if (m_out_valid) begin
                    void'(q_id.pop_front()); void'(q_cnt.pop_front());
                    void'(q_z.pop_front());  void'(q_s.pop_front());
                end
                foreach (q_cnt[i]) if (q_cnt[i] > 0) q_cnt[i] = q_cnt[i] - 1;
                if (m_gnt >= 0) begin
                    q_id.push_back(m_gnt);
                    q_z.push_back(fake_z(req_a[m_gnt*W +: W], req_round[m_gnt*3 +: 3]));
                    q_s.push_back(fake_s(req_a[m_gnt*W +: W], req_round[m_gnt*3 +: 3]));
                    q_cnt.push_back(LAT);
                    m_ptr = (m_gnt + 1) % NREQ;
                end
            end
        end
    endtask

    initial forever begin @(negedge clk); model_eval(); end
    initial forever begin @(posedge clk); model_step(); end

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) req_a[i*W +: W] = $urandom;
        req_round = 12'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; res_ready = 1'b1; flush_req = 1'b0;
        req_a = '0; req_round = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (res_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        n_cmp++; if (res_id !== 2'd0)     begin n_bad++; $display("FAIL reset_res_id got %0d exp 0", res_id); end
        n_cmp++; if (res_z !== 32'd0)     begin n_bad++; $display("FAIL reset_res_z got %h exp 0", res_z); end
        n_cmp++; if (res_status !== 8'd0) begin n_bad++; $display("FAIL reset_res_status got %h exp 0", res_status); end
        n_cmp++; if (inflight !== 2'd0)   begin n_bad++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
        n_cmp++; if (sq_enable !== 1'b1)  begin n_bad++; $display("FAIL reset_sq_enable got %b exp 1", sq_enable); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int  cyc;
        bit  found;
        req_a = '0; req_round = '0;
        req_a[1*W +: W] = 32'h4080_0000;
        req_valid = 4'b0010; res_ready = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 4'b0010)     begin n_bad++; $display("FAIL single_grant got %b exp 0010", req_ready); end
        n_cmp++; if (sq_a !== 32'h4080_0000)    begin n_bad++; $display("FAIL single_sq_a got %h exp 40800000", sq_a); end
        @(posedge clk); #1;
        req_valid = '0;
        found = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk); #1;
            if (res_valid) begin found = 1'b1; break; end
        end
        n_cmp++; if (!found)                    begin n_bad++; $display("FAIL single_timeout got none exp res_valid"); end
        n_cmp++; if (cyc != LAT + 1)            begin n_bad++; $display("FAIL single_latency got %0d exp %0d", cyc, LAT + 1); end
        n_cmp++; if (res_id !== 2'd1)           begin n_bad++; $display("FAIL single_res_id got %0d exp 1", res_id); end
        n_cmp++; if (res_z !== 32'h4000_0000)   begin n_bad++; $display("FAIL single_res_z got %h exp 40000000", res_z); end
        @(posedge clk); #1;
        @(negedge clk); #1;
        n_cmp++; if (res_valid !== 1'b0)        begin n_bad++; $display("FAIL single_dup got %b exp 0", res_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int got[$];
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 4'hF; res_ready = 1'b1;
        randomize_data();
        for (int i = 0; i < 13; i++) begin
            if (i == 8) req_valid = '0;
            @(negedge clk); #1;
            if (i < 8) begin
                n_cmp++; if (req_ready !== (4'b0001 << (i % 4))) begin n_bad++; $display("FAIL b2b_grant cyc %0d got %b exp %b", i, req_ready, 4'b0001 << (i % 4)); end
            end
            n_cmp++; if (res_valid !== exp_res_valid) begin n_bad++; $display("FAIL b2b_res_valid cyc %0d got %b exp %b", i, res_valid, exp_res_valid); end
            if (exp_res_valid) begin
                n_cmp++; if (res_z !== exp_z)         begin n_bad++; $display("FAIL b2b_res_z cyc %0d got %h exp %h", i, res_z, exp_z); end
            end
            if (res_valid && res_ready) got.push_back(int'(res_id));
            @(posedge clk); #1;
            randomize_data();
        end
        n_cmp++; if (got.size() != 8) begin n_bad++; $display("FAIL b2b_count got %0d exp 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_cmp++; if (got[i] != i % 4) begin n_bad++; $display("FAIL b2b_order idx %0d got %0d exp %0d", i, got[i], i % 4); end
        end
    endtask

    task automatic test_stall();
        req_valid = 4'hF; res_ready = 1'b1;
        randomize_data();
        repeat (4) begin @(posedge clk); #1; randomize_data(); end
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (sq_enable !== 1'b0)    begin n_bad++; $display("FAIL stall_sq_enable cyc %0d got %b exp 0", i, sq_enable); end
            n_cmp++; if (req_ready !== 4'b0)    begin n_bad++; $display("FAIL stall_req_ready cyc %0d got %b exp 0000", i, req_ready); end
            n_cmp++; if (res_valid !== 1'b1)    begin n_bad++; $display("FAIL stall_res_valid cyc %0d got %b exp 1", i, res_valid); end
            n_cmp++; if (res_z !== exp_z)       begin n_bad++; $display("FAIL stall_res_z cyc %0d got %h exp %h", i, res_z, exp_z); end
            @(posedge clk); #1;
            randomize_data();
        end
        res_ready = 1'b1; req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (res_valid !== exp_res_valid) begin n_bad++; $display("FAIL stall_drain_valid cyc %0d got %b exp %b", i, res_valid, exp_res_valid); end
            if (exp_res_valid) begin
                n_cmp++; if (res_id !== exp_res_id)   begin n_bad++; $display("FAIL stall_drain_id cyc %0d got %0d exp %0d", i, res_id, exp_res_id); end
                n_cmp++; if (res_z !== exp_z)         begin n_bad++; $display("FAIL stall_drain_z cyc %0d got %h exp %h", i, res_z, exp_z); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        n_cmp++; if (inflight !== 2'd0) begin n_bad++; $display("FAIL stall_empty got %0d exp 0", inflight); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int  pulses;
        int  zero_cyc;
        int  done_cyc;
        bit  done_seen;
        req_valid = 4'hF; res_ready = 1'b1;
        randomize_data();
        repeat (3) begin @(posedge clk); #1; randomize_data(); end
        flush_req = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== exp_req_ready || req_ready === 4'b0) begin n_bad++; $display("FAIL flush_same_cycle_grant got %b exp %b", req_ready, exp_req_ready); end
        @(posedge clk); #1;
        pulses = 0; zero_cyc = -1; done_cyc = -1; done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) flush_req = 1'b0;
            @(negedge clk); #1;
            if (!done_seen) begin
                n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL flush_no_grant cyc %0d got %b exp 0000", i, req_ready); end
            end
            n_cmp++; if (flush_done !== exp_flush_done) begin n_bad++; $display("FAIL flush_done cyc %0d got %b exp %b", i, flush_done, exp_flush_done); end
            n_cmp++; if (inflight !== exp_inflight)     begin n_bad++; $display("FAIL flush_inflight cyc %0d got %0d exp %0d", i, inflight, exp_inflight); end
            if (zero_cyc < 0 && exp_inflight == 2'd0) zero_cyc = i;
            if (flush_done === 1'b1) begin
                pulses++;
                if (!done_seen) done_cyc = i;
                done_seen = 1'b1;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (pulses != 1)                        begin n_bad++; $display("FAIL flush_pulses got %0d exp 1", pulses); end
        n_cmp++; if (zero_cyc < 0 || done_cyc != zero_cyc + 1) begin n_bad++; $display("FAIL flush_timing got %0d exp %0d", done_cyc, zero_cyc + 1); end
        req_valid = '0;
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'hF; res_ready = 1'b1;
        randomize_data();
        repeat (2) begin @(posedge clk); #1; randomize_data(); end
        req_valid = '0;
        @(negedge clk); #1;
        n_cmp++; if (inflight !== 2'd2) begin n_bad++; $display("FAIL rmid_pre_inflight got %0d exp 2", inflight); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (inflight !== 2'd0)  begin n_bad++; $display("FAIL rmid_inflight got %0d exp 0", inflight); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_stale cyc %0d got %b exp 0", i, res_valid); end
            @(posedge clk); #1;
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_ptr got %b exp 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            randomize_data();
            res_ready = ($urandom_range(0, 9) < 7);
            flush_req = ($urandom_range(0, 49) == 0);
            @(negedge clk); #1;
            n_cmp++; if (req_ready !== exp_req_ready)   begin n_bad++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, req_ready, exp_req_ready); end
            n_cmp++; if (sq_enable !== exp_sq_enable)   begin n_bad++; $display("FAIL rnd_sq_enable cyc %0d got %b exp %b", i, sq_enable, exp_sq_enable); end
            n_cmp++; if (sq_a !== exp_sq_a || sq_round !== exp_sq_round) begin n_bad++; $display("FAIL rnd_sq_op cyc %0d got %h/%0d exp %h/%0d", i, sq_a, sq_round, exp_sq_a, exp_sq_round); end
            n_cmp++; if (res_valid !== exp_res_valid)   begin n_bad++; $display("FAIL rnd_res_valid cyc %0d got %b exp %b", i, res_valid, exp_res_valid); end
            n_cmp++; if (inflight !== exp_inflight)     begin n_bad++; $display("FAIL rnd_inflight cyc %0d got %0d exp %0d", i, inflight, exp_inflight); end
            n_cmp++; if (flush_done !== exp_flush_done) begin n_bad++; $display("FAIL rnd_flush_done cyc %0d got %b exp %b", i, flush_done, exp_flush_done); end
            if (exp_res_valid) begin
                n_cmp++; if (res_id !== exp_res_id)     begin n_bad++; $display("FAIL rnd_res_id cyc %0d got %0d exp %0d", i, res_id, exp_res_id); end
                n_cmp++; if (res_z !== exp_z || res_status !== exp_s) begin n_bad++; $display("FAIL rnd_res_data cyc %0d got %h/%h exp %h/%h", i, res_z, res_status, exp_z, exp_s); end
            end
            @(posedge clk); #1;
        end
        req_valid = '0; flush_req = 1'b0; res_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fp_sqrt_scheduler.md
FP_SQRT_SCHEDULER -- requirements
Module: fp_sqrt_scheduler

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (2..8).
REQ-002 Parameter: sig_width, 23, significand width; operand width W = sig_width+ex_width+1.
REQ-003 Parameter: ex_width, 8, exponent width.
REQ-004 Parameter: LAT, 2, register latency of the attached fp_sqrt; equals its pipe_stages (0..3).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: reset  in  1  synchronous reset, active-high.
REQ-008 Port: req_valid  in  NREQ  per-requester operation request.
REQ-009 Port: req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-010 Port: req_a  in  NREQ*W  operands, requester i at bits [i*W +: W].
REQ-011 Port: req_round  in  NREQ*3  rounding modes, requester i at [i*3 +: 3].
REQ-012 Port: res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-013 Port: res_id  out  clog2(NREQ)  requester index of result.
REQ-014 Port: res_z / res_status  out / out  W / 8  result and status flags.
REQ-015 Port: sq_a / sq_round / sq_enable  out / out / out  W / 3 / 1  drive to fp_sqrt a, round, enable.
REQ-016 Port: sq_z / sq_status  in / in  W / 8  from fp_sqrt z, status.
REQ-017 Port: flush_req / flush_done  in / out  1 / 1  drain request; one-cycle completion pulse.
REQ-018 Port: inflight  out  clog2(LAT+2)  ops in sqrt pipeline plus result register.

Function
REQ-019 sq_enable SHALL equal (!res_valid | res_ready); when low, sqrt pipeline, tag pipeline and grants all freeze.
REQ-020 Grant: only in state RUN with sq_enable=1; round-robin among asserted req_valid starting at pointer ptr; req_ready[g]=1 for the winner only, combinationally.
REQ-021 After a grant to g, ptr SHALL become (g+1) mod NREQ; ptr unchanged with no grant.
REQ-022 On grant, sq_a/sq_round = winner's operand/round; otherwise sq_a=0, sq_round=0.
REQ-023 Tag pipeline: LAT entries {valid, id} shifting when sq_enable=1; stage 0 loads {grant, g}; bubble enters when no grant.
REQ-024 Result register: when sq_enable=1, loads {valid, id} from tag-pipeline tail (LAT=0: from current grant) and res_z/res_status from sq_z/sq_status; res_valid clears on handshake with no new valid entry.
REQ-025 Latency: operation accepted in cycle t SHALL present res_valid in cycle t+LAT+1 absent stalls; each stall cycle adds one.
REQ-026 Results SHALL return in acceptance order; throughput one op/cycle with res_ready=1.
REQ-027 res_z/res_status/res_id SHALL hold stable while res_valid=1 and res_ready=0.
REQ-028 inflight = valid tag entries + res_valid; increments on grant, decrements on result handshake, unchanged when both.
REQ-029 FSM states RUN, DRAIN, DONE; RUN->DRAIN on flush_req; DRAIN->DONE when inflight==0; DONE->RUN unconditionally.
REQ-030 No grants in DRAIN or DONE; flush_done=1 only in DONE; flush_req in DRAIN/DONE ignored.
REQ-031 Simultaneous flush_req and request in RUN: the grant that cycle SHALL proceed and be drained.

Reset
REQ-032 On reset: state RUN, ptr=0, all tag valids 0, res_valid=0, res_id=0, res_z=0, res_status=0, flush_done=0, inflight=0.
REQ-033 Reset mid-operation SHALL discard all in-flight ops; no res_valid for them after reset.

Verification
REQ-034 LAT=2, req 1 a=0x40800000 (4.0), res_ready=1 -> res_valid at t+3, res_id=1, res_z=0x40000000.
REQ-035 All four req_valid held, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; results in same order.
REQ-036 res_ready=0 for 5 cycles with pipeline full -> sq_enable=0, req_ready=0, res_z stable; resumes without loss or duplication.
REQ-037 flush_req with 3 ops in flight -> no grants; flush_done one pulse one cycle after inflight reaches 0.
REQ-038 reset asserted with 2 ops in flight -> next cycle inflight=0, res_valid=0; no stale results; ptr=0.
